ahb_manager_arbiter: RTL and testbench

- Shares one AHB subordinate-side address/data path among ManagerNum managers.
- Round-robin arbitration, performed only at transfer and burst boundaries.
- Honours per-manager lock.
- Muxes the address phase by the registered grant and the write data by the registered data-phase owner.
- Sits between the managers and the address decoder / subordinate mux of the shared bus.

---
 rtl/ahb_manager_arbiter.sv | 116 +++++++++++
 tb/tb_ahb_manager_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_manager_arbiter.sv
// Round-robin AHB manager arbiter: muxes the address phase by grant, write data by data-phase owner.
// Optional owner hold limit enabled by defining AHB_ARB_HOLD_LIMIT_EN.
module ahb_manager_arbiter #(
  parameter int unsigned ManagerNum = 2,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned HoldLimit  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ManagerNum-1:0]           req,
  input  logic [ManagerNum-1:0]           lock,
  input  logic [ManagerNum*AddrWidth-1:0] mAddr,
  input  logic [ManagerNum*2-1:0]         mTrans,
  input  logic [ManagerNum-1:0]           mWrite,
  input  logic [ManagerNum*DataWidth-1:0] mWdata,
  input  logic                            hready,
  output logic [ManagerNum-1:0]           grant,
  output logic [ManagerNum-1:0]           dataOwner,
  output logic [AddrWidth-1:0]            sAddr,
  output logic [1:0]                      sTrans,
  output logic                            sWrite,
  output logic [DataWidth-1:0]            sWdata
);

  localparam int unsigned IdxW = (ManagerNum > 1) ? $clog2(ManagerNum) : 1;
  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  // Owners are kept as indices so grant/dataOwner are one-hot by construction.
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] downer_q, downer_d;
  logic [IdxW-1:0] next_idx, cand;
  logic            found;
  logic [1:0]      owner_trans;
  logic            owner_req, owner_lock;
  logic            others_req;
  logic            arb_ok, hold_hit, arb, grant_change;

  assign owner_trans = mTrans[owner_q*2 +: 2];
  assign owner_req   = req[owner_q];
  assign owner_lock  = lock[owner_q];
  assign others_req  = |(req & ~grant);

  assign arb_ok = hready && ((owner_trans == TransIdle) || !owner_req) &&
                  !(owner_lock && owner_req);

  // Scan owner+1 upward with wrap; the current owner is visited last.
  always_comb begin
    found    = 1'b0;
    next_idx = owner_q;
    cand     = owner_q;
    for (int unsigned k = 0; k < ManagerNum; k++) begin
      cand = (cand == IdxW'(ManagerNum - 1)) ? '0 : cand + IdxW'(1);
      if (!found && req[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

`ifdef AHB_ARB_HOLD_LIMIT_EN
  localparam int unsigned CntW = $clog2(HoldLimit + 1);
  logic [CntW-1:0] hold_q, hold_d;

  assign hold_hit = (hold_q == CntW'(HoldLimit)) && !owner_lock && hready &&
                    ((owner_trans == TransIdle) || (owner_trans == TransNonseq));

  always_comb begin
    hold_d = hold_q;
    if (grant_change) begin
      hold_d = '0;
    end else if (hready && others_req && (hold_q != CntW'(HoldLimit))) begin
      hold_d = hold_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  assign arb          = arb_ok || hold_hit;
  assign grant_change = arb && found && (next_idx != owner_q);

  always_comb begin
    owner_d  = grant_change ? next_idx : owner_q;
    downer_d = hready ? owner_q : downer_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= '0;
      downer_q <= '0;
    end else begin
      owner_q  <= owner_d;
      downer_q <= downer_d;
    end
  end

  always_comb begin
    grant     = ManagerNum'(1) << owner_q;
    dataOwner = ManagerNum'(1) << downer_q;
    sAddr     = mAddr[owner_q*AddrWidth +: AddrWidth];
    sTrans    = owner_req ? owner_trans : TransIdle;
    sWrite    = mWrite[owner_q];
    sWdata    = mWdata[downer_q*DataWidth +: DataWidth];
  end

endmodule

// File: tb/tb_ahb_manager_arbiter.sv
// Bench for ahb_manager_arbiter: directed vector table, hand sequences, random vs. behavioural model.
module tb_ahb_manager_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int HL = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, lock, mWrite, grant, dataOwner;
  logic [N*AW-1:0] mAddr;
  logic [N*2-1:0]  mTrans;
  logic [N*DW-1:0] mWdata;
  logic            hready;
  logic [AW-1:0]   sAddr;
  logic [1:0]      sTrans;
  logic            sWrite;
  logic [DW-1:0]   sWdata;

  ahb_manager_arbiter #(
    .ManagerNum(N),
    .AddrWidth (AW),
    .DataWidth (DW),
    .HoldLimit (HL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .lock     (lock),
    .mAddr    (mAddr),
    .mTrans   (mTrans),
    .mWrite   (mWrite),
    .mWdata   (mWdata),
    .hready   (hready),
    .grant    (grant),
    .dataOwner(dataOwner),
    .sAddr    (sAddr),
    .sTrans   (sTrans),
    .sWrite   (sWrite),
    .sWdata   (sWdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] trans;
    logic       hready;
    logic [3:0] grant;
    logic [3:0] downer;
  } vec_t;

  vec_t vecs[10];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_owner, m_downer, m_hold;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  function automatic logic bit_at(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic logic [1:0] trans_of(input int i);
    logic [N*2-1:0] s;
    s = mTrans >> (2 * i);
    return s[1:0];
  endfunction

  // Reference: owner/data owner as integers, next owner by rotated search.
  task automatic model_step();
    int o, nxt;
    logic [1:0] t;
    logic own_req, arb, others;
    if (reset) begin
      m_owner = 0; m_downer = 0; m_hold = 0;
      return;
    end
    if (!hready) return;
    o       = m_owner;
    t       = trans_of(o);
    own_req = bit_at(req, o);
    arb     = ((t == 2'b00) || !own_req) && !(bit_at(lock, o) && own_req);
`ifdef AHB_ARB_HOLD_LIMIT_EN
    if (m_hold == HL && !bit_at(lock, o) && (t == 2'b00 || t == 2'b10)) arb = 1'b1;
`endif
    nxt = o;
    if (arb) begin
      for (int k = 1; k <= N; k++) begin
        if (bit_at(req, (o + k) % N)) begin
          nxt = (o + k) % N;
          break;
        end
      end
    end
    others   = (req & ~onehot(o)) != '0;
    m_downer = o;
    if (nxt != o) begin
      m_owner = nxt;
      m_hold  = 0;
    end else if (others && m_hold < HL) begin
      m_hold++;
    end
  endtask

  task automatic check_model();
    int o;
    o = m_owner;
    chk("m_grant", 64'(grant), 64'(onehot(o)));
    chk("m_downer", 64'(dataOwner), 64'(onehot(m_downer)));
    chk("m_saddr", 64'(sAddr), 64'(mAddr[AW*o +: AW]));
    chk("m_strans", 64'(sTrans), bit_at(req, o) ? 64'(trans_of(o)) : 64'(0));
    chk("m_swrite", 64'(sWrite), 64'(bit_at(mWrite, o)));
    chk("m_swdata", 64'(sWdata), 64'(mWdata[DW*m_downer +: DW]));
  endtask

  task automatic pre();
    #3;
  endtask

  task automatic post();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_trans(input int i, input logic [1:0] t);
    mTrans[2*i +: 2] = t;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; lock = '0; mTrans = '0; hready = 1'b1;
    pre(); post();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hAA, 1'b1, 4'b0001, 4'b0001};
    vecs[1] = '{8'h00, 1'b1, 4'b0001, 4'b0001};
    vecs[2] = '{8'hAA, 1'b1, 4'b0010, 4'b0001};
    vecs[3] = '{8'h00, 1'b0, 4'b0010, 4'b0010};
    vecs[4] = '{8'h00, 1'b1, 4'b0010, 4'b0010};
    vecs[5] = '{8'hAA, 1'b1, 4'b0100, 4'b0010};
    vecs[6] = '{8'h00, 1'b1, 4'b0100, 4'b0100};
    vecs[7] = '{8'hAA, 1'b1, 4'b1000, 4'b0100};
    vecs[8] = '{8'h00, 1'b1, 4'b1000, 4'b1000};
    vecs[9] = '{8'hAA, 1'b1, 4'b0001, 4'b1000};

    reset = 1'b1; req = '0; lock = '0; mTrans = '0; hready = 1'b1;
    mWrite = 4'b0101;
    for (int i = 0; i < N; i++) begin
      mAddr[AW*i +: AW]  = 32'hA000_0000 + 32'(i);
      mWdata[DW*i +: DW] = 32'hD000_0000 + 32'(i);
    end
    m_owner = 0; m_downer = 0; m_hold = 0;
    @(posedge clk); #1;

    // Reset held two cycles with both requesting, then release with manager 0 idle.
    req = 4'b0011;
    set_trans(0, 2'b10);
    for (int c = 0; c < 2; c++) begin
      pre();
      chk("rst_grant", 64'(grant), 64'(4'b0001));
      chk("rst_downer", 64'(dataOwner), 64'(4'b0001));
      chk("rst_strans", 64'(sTrans), 64'(2'b10));
      post();
    end
    reset = 1'b0;
    set_trans(0, 2'b00);
    pre(); post();
    pre(); chk("rst_release", 64'(grant), 64'(4'b0010)); post();

    // Round-robin across four managers, including a frozen hready=0 cycle.
    do_reset();
    req = 4'b1111;
    foreach (vecs[i]) begin
      mTrans = vecs[i].trans;
      hready = vecs[i].hready;
      pre();
      chk("rr_grant", 64'(grant), 64'(vecs[i].grant));
      chk("rr_downer", 64'(dataOwner), 64'(vecs[i].downer));
      post();
    end

    // Burst interior must not be split.
    do_reset();
    req = 4'b0011;
    foreach (vecs[i]) begin
      if (i > 4) break;
      case (i)
        0:       set_trans(0, 2'b10);
        4:       set_trans(0, 2'b00);
        default: set_trans(0, 2'b11);
      endcase
      pre(); chk("burst_hold", 64'(grant), 64'(4'b0001)); post();
    end
    pre(); chk("burst_switch", 64'(grant), 64'(4'b0010)); post();

    // Wait states after owner 0's last beat.
    do_reset();
    req = 4'b0011;
    set_trans(0, 2'b10);
    pre(); post();
    set_trans(0, 2'b00);
    hready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      pre();
      chk("ws_grant", 64'(grant), 64'(4'b0001));
      chk("ws_downer", 64'(dataOwner), 64'(4'b0001));
      chk("ws_wdata", 64'(sWdata), 64'(32'hD000_0000));
      post();
    end
    hready = 1'b1;
    pre(); chk("ws_arb_grant", 64'(grant), 64'(4'b0001)); post();
    pre();
    chk("ws_new_grant", 64'(grant), 64'(4'b0010));
    chk("ws_old_downer", 64'(dataOwner), 64'(4'b0001));
    chk("ws_old_wdata", 64'(sWdata), 64'(32'hD000_0000));
    post();
    pre();
    chk("ws_new_downer", 64'(dataOwner), 64'(4'b0010));
    chk("ws_new_wdata", 64'(sWdata), 64'(32'hD000_0001));
    post();

    // Lock held by owner 1.
    do_reset();
    req = 4'b0010;
    pre(); post();
    req  = 4'b0011;
    lock = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      pre(); chk("lock_hold", 64'(grant), 64'(4'b0010)); post();
    end
    lock = 4'b0000;
    pre(); chk("lock_drop_same", 64'(grant), 64'(4'b0010)); post();
    pre(); chk("lock_release", 64'(grant), 64'(4'b0001)); post();

    // Owner 0 streams NONSEQ while manager 1 waits.
    do_reset();
    req = 4'b0011;
    set_trans(0, 2'b10);
`ifdef AHB_ARB_HOLD_LIMIT_EN
    for (int c = 0; c < 6; c++) begin
      pre();
      chk("hold_limit", 64'(grant), (c < 5) ? 64'(4'b0001) : 64'(4'b0010));
      post();
    end
`else
    for (int c = 0; c < 50; c++) begin
      pre(); chk("hold_forever", 64'(grant), 64'(4'b0001)); post();
    end
`endif

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset  = ($urandom_range(0, 59) == 0);
      req    = N'($urandom);
      lock   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      mTrans = 8'($urandom);
      hready = ($urandom_range(0, 3) != 0);
      mWrite = N'($urandom);
      for (int i = 0; i < N; i++) begin
        mAddr[AW*i +: AW]  = $urandom;
        mWdata[DW*i +: DW] = $urandom;
      end
      pre(); check_model(); post();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
